// File: rtl/in_port_sync.sv
// in_port_sync: input-port reader for the CPU IN path.
// Raw switch lines pass through a two-flop synchronizer. The synchronized value
// is debounced: it must hold for DEBOUNCE consecutive cycles (legal range 1..255)
// before it is committed to rd_data.
// The changed output pulses for one cycle on each commit.
// Optional macro IN_PORT_STICKY_EN: changed becomes a sticky flag that a
// core read (rd_en) clears. If a commit and a read happen in the same cycle,
// the commit wins and changed stays set.

module in_port_sync #(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             changed,
    output logic             pending
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic {
        STABLE,
        COUNTING
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] candidate;
    logic [CW-1:0]    cnt;

`ifndef IN_PORT_STICKY_EN
    // The read strobe only matters for the sticky flag.
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
`endif

    // Two-flop synchronizer. Only sync2 is used by the debounce logic.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            // NOTE: non-blocking so sync2 takes last cycle's sync1, giving two real stages.
            sync1 <= sw_in;
            sync2 <= sync1;
        end
    end

    // Debounce FSM: track a candidate value and commit it once it has been stable long enough.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= STABLE;
            candidate <= '0;
            cnt       <= '0;
            rd_data   <= '0;
            changed   <= 1'b0;
            pending   <= 1'b0;
        end else begin
`ifdef IN_PORT_STICKY_EN
            // A read clears the flag. A commit later in this block overrides the clear.
            if (rd_en) begin
                changed <= 1'b0;
            end
`else
            changed <= 1'b0;
`endif
            case (state)
                STABLE: begin
                    if (sync2 != rd_data) begin
                        if (DEBOUNCE == 1) begin
                            rd_data <= sync2;
                            changed <= 1'b1;
                        end else begin
                            candidate <= sync2;
                            cnt       <= CW'(1);
                            state     <= COUNTING;
                            pending   <= 1'b1;
                        end
                    end
                end
                COUNTING: begin
                    if (sync2 == rd_data) begin
                        // The input bounced back to the committed value: abandon the candidate.
                        cnt     <= '0;
                        state   <= STABLE;
                        pending <= 1'b0;
                    end else if (sync2 != candidate) begin
                        // A different new value appeared: restart the count on it.
                        candidate <= sync2;
                        cnt       <= CW'(1);
                    end else if (cnt == CNT_LAST) begin
                        rd_data <= candidate;
                        changed <= 1'b1;
                        cnt     <= '0;
                        state   <= STABLE;
                        pending <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= STABLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_in_port_sync.sv
// tb_in_port_sync: scoreboard bench for in_port_sync.
// Two instances receive the same stimulus: one with DEBOUNCE=4 and one with
// DEBOUNCE=1.
// The reference model works on the run length of the synchronized value:
// a value different from the committed one is committed once it has been
// seen for DEBOUNCE consecutive cycles.

module tb_in_port_sync;

    logic       clk;
    logic       n_rst;
    logic [3:0] sw_in;
    logic       rd_en;
    logic [3:0] rd_data4, rd_data1;
    logic       changed4, changed1;
    logic       pending4, pending1;

    int errors = 0;
    int checks = 0;

    in_port_sync #(.WIDTH(4), .DEBOUNCE(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .sw_in(sw_in), .rd_en(rd_en),
        .rd_data(rd_data4), .changed(changed4), .pending(pending4)
    );

    in_port_sync #(.WIDTH(4), .DEBOUNCE(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .sw_in(sw_in), .rd_en(rd_en),
        .rd_data(rd_data1), .changed(changed1), .pending(pending1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state. h1 and h2 hold the input samples taken one and
    // two edges ago; h2 is the value the debouncer sees.
    typedef struct {
        logic [3:0] h1;
        logic [3:0] h2;
        logic [3:0] last_s;
        int         run;
        logic [3:0] rd;
        logic       chg;
        logic       pend;
    } mdl_t;

    typedef struct {
        logic [3:0] rd4;
        logic [3:0] rd1;
        logic       ch4;
        logic       ch1;
        logic       pe4;
        logic       pe1;
    } exp_t;

    mdl_t m4, m1;
    exp_t exp_q[$];
    exp_t got;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.h1 = '0; m.h2 = '0; m.last_s = '0; m.run = 0;
        m.rd = '0; m.chg = 1'b0; m.pend = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int d, logic [3:0] sw, logic re);
        mdl_t       n;
        logic [3:0] s;
        logic       commit;
        n      = m;
        s      = m.h2;
        commit = 1'b0;
        n.run    = (m.run > 0 && s == m.last_s) ? m.run + 1 : 1;
        n.last_s = s;
        if (s != m.rd && n.run >= d) begin
            n.rd   = s;
            commit = 1'b1;
        end
`ifdef IN_PORT_STICKY_EN
        n.chg = commit | (m.chg & ~re);
`else
        n.chg = commit;
        if (re) n.chg = commit;
`endif
        n.pend = (s != n.rd);
        n.h2   = m.h1;
        n.h1   = sw;
        return n;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: on every rising edge, predict the outputs and queue them.
    initial begin
        m4 = mdl_reset();
        m1 = mdl_reset();
    end

    always @(posedge clk) begin
        if (!n_rst) begin
            m4 = mdl_reset();
            m1 = mdl_reset();
        end else begin
            m4 = mdl_step(m4, 4, sw_in, rd_en);
            m1 = mdl_step(m1, 1, sw_in, rd_en);
        end
        exp_q.push_back('{rd4: m4.rd, rd1: m1.rd, ch4: m4.chg, ch1: m1.chg,
                          pe4: m4.pend, pe1: m1.pend});
    end

    // Monitor: shortly after each rising edge, compare the outputs with the oldest prediction.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            got = exp_q.pop_front();
            check("rd_data_d4", {4'h0, rd_data4}, {4'h0, got.rd4});
            check("changed_d4", {7'h0, changed4}, {7'h0, got.ch4});
            check("pending_d4", {7'h0, pending4}, {7'h0, got.pe4});
            check("rd_data_d1", {4'h0, rd_data1}, {4'h0, got.rd1});
            check("changed_d1", {7'h0, changed1}, {7'h0, got.ch1});
            check("pending_d1", {7'h0, pending1}, {7'h0, got.pe1});
        end
    end

    // Drive a value on the switch lines and hold it for n cycles. Inputs change on falling edges.
    task automatic hold(input logic [3:0] v, input int n);
        sw_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd4"}, {4'h0, rd_data4}, 8'h00);
        check({tag, "_ch4"}, {7'h0, changed4}, 8'h00);
        check({tag, "_pe4"}, {7'h0, pending4}, 8'h00);
        check({tag, "_rd1"}, {4'h0, rd_data1}, 8'h00);
    endtask

    initial begin
        int r;
        n_rst = 1'b0;
        sw_in = 4'hF;
        rd_en = 1'b0;

        // Reset held with all switches high: outputs must stay at zero.
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        n_rst = 1'b1;
        hold(4'hF, 8);

        // Clean change, followed by a short glitch.
        hold(4'h0, 8);
        hold(4'hA, 8);
        hold(4'h0, 8);
        hold(4'h3, 2);
        hold(4'h0, 8);

        // Bounce to a new value before the first one commits.
        hold(4'h1, 2);
        hold(4'h2, 8);

        // Asynchronous reset while the counter holds 2.
        hold(4'h5, 8);
        sw_in = 4'h6;
        repeat (4) @(posedge clk);
        #3 n_rst = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        hold(4'h6, 8);

        // Sticky flag: wait, then issue a single read pulse.
        hold(4'h9, 12);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        hold(4'h9, 3);

        // A read strobe that overlaps the commit cycle.
        sw_in = 4'hC;
        repeat (4) @(negedge clk);
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b0;
        hold(4'hC, 4);

        // Randomized phase: small value alphabet to create frequent bounces and glitches.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 4);
            sw_in = (r == 4) ? 4'($urandom) : 4'(r);
            for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
                rd_en = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        rd_en = 1'b0;
        hold(sw_in, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
